// File: rtl/button_event_fsm.sv
// rtl/button_event_fsm.sv - classifies a debounced button level into press/release/short/long/double-click strobes
// Double-click detection is compiled in only when BUTTON_DOUBLE_CLICK_EN is defined.
module button_event_fsm #(
  parameter int unsigned LONG_TICKS = 1000,
  parameter int unsigned GAP_TICKS  = 300,
  parameter int unsigned CNT_W      = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_in,
  output logic       press,
  output logic       released,
  output logic       short_press,
  output logic       long_press,
  output logic       double_click,
  output logic       held,
  output logic [7:0] press_cnt
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] PRESSED   = 3'd1;
  localparam logic [2:0] LONG_HELD = 3'd2;
`ifdef BUTTON_DOUBLE_CLICK_EN
  localparam logic [2:0] WAIT_GAP  = 3'd3;
  localparam logic [2:0] SECOND    = 3'd4;
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_TICKS - 1);
`endif
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);

  if (LONG_TICKS < 2 || GAP_TICKS < 1) begin : g_param_check
    $error("button_event_fsm: LONG_TICKS must be >= 2 and GAP_TICKS >= 1");
  end

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             btn_q, btn_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             short_q, short_d;
  logic             long_q, long_d;
  logic             dbl_q, dbl_d;
  logic             held_q, held_d;
  logic [7:0]       press_cnt_q, press_cnt_d;
  logic             rise, fall;

  always_comb begin
    rise        = btn_in & ~btn_q;
    fall        = ~btn_in & btn_q;
    btn_d       = btn_in;
    state_d     = state_q;
    cnt_d       = cnt_q;
    press_d     = rise;
    release_d   = fall;
    short_d     = 1'b0;
    long_d      = 1'b0;
    dbl_d       = 1'b0;
    press_cnt_d = press_cnt_q + 8'(rise);

    // Edges are tested before timeouts so an edge wins on a coincident cycle.
    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end
      end
      PRESSED: begin
        if (fall) begin
`ifdef BUTTON_DOUBLE_CLICK_EN
          state_d = WAIT_GAP;
          cnt_d   = '0;
`else
          state_d = IDLE;
          short_d = 1'b1;
`endif
        end else if (cnt_q == LONG_LAST) begin
          state_d = LONG_HELD;
          long_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      LONG_HELD: begin
        if (fall) state_d = IDLE;
      end
`ifdef BUTTON_DOUBLE_CLICK_EN
      WAIT_GAP: begin
        if (rise) begin
          state_d = SECOND;
          dbl_d   = 1'b1;
        end else if (cnt_q == GAP_LAST) begin
          state_d = IDLE;
          short_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SECOND: begin
        if (fall) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase

    held_d = (state_d == LONG_HELD);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      btn_q       <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      short_q     <= 1'b0;
      long_q      <= 1'b0;
      dbl_q       <= 1'b0;
      held_q      <= 1'b0;
      press_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      btn_q       <= btn_d;
      press_q     <= press_d;
      release_q   <= release_d;
      short_q     <= short_d;
      long_q      <= long_d;
      dbl_q       <= dbl_d;
      held_q      <= held_d;
      press_cnt_q <= press_cnt_d;
    end
  end

  assign press        = press_q;
  assign released     = release_q;
  assign short_press  = short_q;
  assign long_press   = long_q;
  assign double_click = dbl_q;
  assign held         = held_q;
  assign press_cnt    = press_cnt_q;

endmodule
